writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back logic; the writer end of the register-file port consumed by decode.

---
 rtl/writeback_stage.sv | 207 ++++++++++++++++++++
 tb/tb_writeback_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_stage
//  Purpose  : MEM/WB pipeline register plus write-back logic. Registers the
//             MEM-stage results, selects ALU / load / link data, extracts and
//             extends sub-word loads, drives the register-file write port and
//             the WB forwarding bus, counts retired instructions and flags
//             misaligned loads.
//  Ports    : i_clk, i_reset          clock / synchronous active-high reset
//             i_valid, i_stall,       MEM-stage handshake: valid instruction,
//             i_flush                 hold register, squash register
//             i_reg_write, i_dest_addr, i_wb_sel, i_load_type,
//             i_alu_result, i_mem_rdata, i_link_addr   MEM-stage payload
//             o_wb_en/addr/data       register-file write port
//             o_fwd_valid             forwarding-bus valid (== o_wb_en)
//             o_misalign              one-cycle pulse, misaligned load squashed
//             o_misalign_err          sticky misaligned-load flag
//             o_retire_count          retired-instruction counter
//  Revision : 1.0  initial release
// ============================================================================
module writeback_stage #(
    parameter int COUNT_W    = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_reg_write,
    input  logic [4:0]         i_dest_addr,
    input  logic [1:0]         i_wb_sel,
    input  logic [2:0]         i_load_type,
    input  logic [31:0]        i_alu_result,
    input  logic [31:0]        i_mem_rdata,
    input  logic [31:0]        i_link_addr,
    output logic               o_wb_en,
    output logic [4:0]         o_wb_addr,
    output logic [31:0]        o_wb_data,
    output logic               o_fwd_valid,
    output logic               o_misalign,
    output logic               o_misalign_err,
    output logic [COUNT_W-1:0] o_retire_count
);

    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_LINK = 2'b10;

    localparam logic [2:0] c_LD_LW  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LHU = 3'b010;
    localparam logic [2:0] c_LD_LB  = 3'b011;
    localparam logic [2:0] c_LD_LBU = 3'b100;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic               valid_q,     valid_d;
    logic               reg_write_q, reg_write_d;
    logic [4:0]         dest_q,      dest_d;
    logic [1:0]         wb_sel_q,    wb_sel_d;
    logic [2:0]         load_type_q, load_type_d;
    logic [31:0]        alu_q,       alu_d;
    logic [31:0]        rdata_q,     rdata_d;
    logic [31:0]        link_q,      link_d;
    logic               err_q,       err_d;
    logic [COUNT_W-1:0] retire_q,    retire_d;

    logic               w_misaligned;
    logic               w_leave;
    logic               w_mis_pulse;

    // An instruction leaves the stage on any cycle it is neither held nor
    // squashed; that is also the only cycle it may write or raise misalign.
    assign w_leave     = valid_q & ~i_stall & ~i_flush;
    assign w_mis_pulse = w_leave & w_misaligned & ~i_reset;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        dest_d      = dest_q;
        wb_sel_d    = wb_sel_q;
        load_type_d = load_type_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        link_d      = link_q;
        err_d       = err_q;
        retire_d    = retire_q;

        if (i_flush) begin
            valid_d = 1'b0;
        end else if (!i_stall) begin
            valid_d     = i_valid;
            reg_write_d = i_reg_write;
            dest_d      = i_dest_addr;
            wb_sel_d    = i_wb_sel;
            load_type_d = i_load_type;
            alu_d       = i_alu_result;
            rdata_d     = i_mem_rdata;
            link_d      = i_link_addr;
        end

        if (w_leave) begin
            retire_d = retire_q + 1'b1;
        end
        if (w_mis_pulse) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            dest_q      <= 5'd0;
            wb_sel_q    <= 2'b00;
            load_type_q <= 3'b000;
            alu_q       <= 32'd0;
            rdata_q     <= 32'd0;
            link_q      <= 32'd0;
            err_q       <= 1'b0;
            retire_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            dest_q      <= dest_d;
            wb_sel_q    <= wb_sel_d;
            load_type_q <= load_type_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            link_q      <= link_d;
            err_q       <= err_d;
            retire_q    <= retire_d;
        end
    end

    // ------------------------------------------------------------------
    // Load lane extraction
    // ------------------------------------------------------------------
    logic [1:0]  w_off;
    logic [1:0]  w_lane;
    logic        w_half_hi;
    logic [31:0] w_byte_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_result;

    assign w_off = alu_q[1:0];

    // Big-endian byte offset k lives in lane 3-k, i.e. the bitwise inverse.
    assign w_lane      = BIG_ENDIAN ? ~w_off : w_off;
    assign w_byte_word = rdata_q >> {w_lane, 3'b000};
    assign w_byte      = w_byte_word[7:0];

    assign w_half_hi = BIG_ENDIAN ? ~w_off[1] : w_off[1];
    assign w_half    = w_half_hi ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        w_load_data = rdata_q;
        case (load_type_q)
            c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_load_data = {16'd0, w_half};
            c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_load_data = {24'd0, w_byte};
            default:  w_load_data = rdata_q;
        endcase
    end

    // Offset only matters for loads; byte loads can never be misaligned and
    // undefined load types behave as LW.
    always_comb begin
        w_misaligned = 1'b0;
        if (wb_sel_q == c_SEL_LOAD) begin
            case (load_type_q)
                c_LD_LH, c_LD_LHU: w_misaligned = w_off[0];
                c_LD_LB, c_LD_LBU: w_misaligned = 1'b0;
                default:           w_misaligned = (w_off != 2'b00);
            endcase
        end
    end

    always_comb begin
        w_result = alu_q;
        case (wb_sel_q)
            c_SEL_ALU:  w_result = alu_q;
            c_SEL_LOAD: w_result = w_load_data;
            c_SEL_LINK: w_result = link_q;
            default:    w_result = alu_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_wb_en        = w_leave & reg_write_q & (dest_q != 5'd0)
                          & ~w_misaligned & ~i_reset;
    assign o_fwd_valid    = o_wb_en;
    assign o_wb_addr      = dest_q;
    assign o_wb_data      = valid_q ? w_result : 32'd0;
    assign o_misalign     = w_mis_pulse;
    assign o_misalign_err = err_q;
    assign o_retire_count = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_stage
//  Purpose  : Self-checking bench for writeback_stage. Two instances share the
//             stimulus: A (COUNT_W=4, big-endian) and B (COUNT_W=8,
//             little-endian). A scoreboard queue holds the expected write-back
//             of the instruction sitting in the MEM/WB register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk;
    logic        rst, v, st, fl, rw;
    logic [4:0]  dst;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [31:0] alu, rdat, lnk;

    logic        en_a, fwd_a, mis_a, err_a, en_b, fwd_b, mis_b, err_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  cnt_a;
    logic [7:0]  cnt_b;

    writeback_stage #(.COUNT_W(4), .BIG_ENDIAN(1'b1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_valid(v), .i_stall(st), .i_flush(fl),
        .i_reg_write(rw), .i_dest_addr(dst), .i_wb_sel(sel), .i_load_type(lt),
        .i_alu_result(alu), .i_mem_rdata(rdat), .i_link_addr(lnk),
        .o_wb_en(en_a), .o_wb_addr(addr_a), .o_wb_data(data_a),
        .o_fwd_valid(fwd_a), .o_misalign(mis_a), .o_misalign_err(err_a),
        .o_retire_count(cnt_a)
    );

    writeback_stage #(.COUNT_W(8), .BIG_ENDIAN(1'b0)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_valid(v), .i_stall(st), .i_flush(fl),
        .i_reg_write(rw), .i_dest_addr(dst), .i_wb_sel(sel), .i_load_type(lt),
        .i_alu_result(alu), .i_mem_rdata(rdat), .i_link_addr(lnk),
        .o_wb_en(en_b), .o_wb_addr(addr_b), .o_wb_data(data_b),
        .o_fwd_valid(fwd_b), .o_misalign(mis_b), .o_misalign_err(err_b),
        .o_retire_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] dbe;
        logic [31:0] dle;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_m = 0;
    bit   err_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model of the write-back value, built from a byte view of the word.
    function automatic logic [31:0] ref_data(input bit be, input logic [1:0] s,
        input logic [2:0] t, input logic [31:0] a, input logic [31:0] r, input logic [31:0] l);
        logic [7:0]  b [4];
        logic [15:0] hw;
        int          o, h;
        for (int k = 0; k < 4; k++)
            b[k] = be ? r[8*(3-k) +: 8] : r[8*k +: 8];
        o = int'(a[1:0]);
        h = o & 2;
        hw = be ? {b[h], b[h+1]} : {b[h+1], b[h]};
        if (s == 2'b10) return l;
        if (s != 2'b01) return a;
        case (t)
            3'd1:    return {{16{hw[15]}}, hw};
            3'd2:    return {16'h0000, hw};
            3'd3:    return {{24{b[o][7]}}, b[o]};
            3'd4:    return {24'h000000, b[o]};
            default: return r;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [1:0] s, input logic [2:0] t, input logic [31:0] a);
        if (s != 2'b01) return 1'b0;
        if (t == 3'd1 || t == 3'd2) return a[0];
        if (t == 3'd3 || t == 3'd4) return 1'b0;
        return a[1:0] != 2'b00;
    endfunction

    // One clock cycle: drive at negedge, check mid-low phase, update model at posedge.
    task automatic step(input bit r_, input bit v_, input bit st_, input bit fl_, input bit rw_,
        input logic [4:0] d_, input logic [1:0] s_, input logic [2:0] t_,
        input logic [31:0] a_, input logic [31:0] rd_, input logic [31:0] l_);
        exp_t e;
        bit   have, live;
        @(negedge clk);
        rst = r_; v = v_; st = st_; fl = fl_; rw = rw_;
        dst = d_; sel = s_; lt = t_; alu = a_; rdat = rd_; lnk = l_;
        #1;
        have = (sb.size() > 0);
        e    = '{1'b0, 5'd0, 32'd0, 32'd0, 1'b0};
        if (have) e = sb[0];
        live = have && !st_ && !fl_ && !r_;
        check("wb_en_a",  {31'd0, en_a},  {31'd0, live && e.en});
        check("wb_en_b",  {31'd0, en_b},  {31'd0, live && e.en});
        check("fwd_a",    {31'd0, fwd_a}, {31'd0, live && e.en});
        check("data_a",   data_a, have ? e.dbe : 32'd0);
        check("data_b",   data_b, have ? e.dle : 32'd0);
        if (have) begin
            check("addr_a", {27'd0, addr_a}, {27'd0, e.addr});
            check("addr_b", {27'd0, addr_b}, {27'd0, e.addr});
        end
        check("mis_a",    {31'd0, mis_a}, {31'd0, live && e.mis});
        check("mis_b",    {31'd0, mis_b}, {31'd0, live && e.mis});
        check("err_a",    {31'd0, err_a}, {31'd0, err_m});
        check("err_b",    {31'd0, err_b}, {31'd0, err_m});
        check("cnt_a",    {28'd0, cnt_a}, 32'(cnt_m % 16));
        check("cnt_b",    {24'd0, cnt_b}, 32'(cnt_m % 256));
        @(posedge clk);
        if (r_) begin
            sb.delete();
            cnt_m = 0;
            err_m = 1'b0;
        end else if (fl_) begin
            sb.delete();
        end else if (!st_) begin
            if (have) begin
                cnt_m++;
                if (e.mis) err_m = 1'b1;
                void'(sb.pop_front());
            end
            if (v_) begin
                e.mis  = ref_mis(s_, t_, a_);
                e.en   = rw_ && (d_ != 5'd0) && !e.mis;
                e.addr = d_;
                e.dbe  = ref_data(1'b1, s_, t_, a_, rd_, l_);
                e.dle  = ref_data(1'b0, s_, t_, a_, rd_, l_);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0);
    endtask

    localparam logic [31:0] c_RD = 32'h80FF_7F01;

    initial begin
        rst = 1'b1; v = 1'b0; st = 1'b0; fl = 1'b0; rw = 1'b0;
        dst = 5'd0; sel = 2'b00; lt = 3'd0; alu = 32'd0; rdat = 32'd0; lnk = 32'd0;
        repeat (2) @(posedge clk);

        // Reset held with valid traffic present
        step(1, 1, 0, 0, 1, 5'd9, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
        step(1, 1, 0, 0, 1, 5'd9, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);

        // ALU write, then write to r0 (suppressed but retires)
        step(0, 1, 0, 0, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
        step(0, 1, 0, 0, 1, 5'd0, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 32'd0);
        idle();

        // Sub-word loads from 0x80FF7F01
        step(0, 1, 0, 0, 1, 5'd10, 2'b01, 3'd3, 32'h0000_1001, c_RD, 32'd0); // LB  off1
        step(0, 1, 0, 0, 1, 5'd11, 2'b01, 3'd4, 32'h0000_1003, c_RD, 32'd0); // LBU off3
        step(0, 1, 0, 0, 1, 5'd12, 2'b01, 3'd1, 32'h0000_1000, c_RD, 32'd0); // LH  off0
        step(0, 1, 0, 0, 1, 5'd13, 2'b01, 3'd2, 32'h0000_1002, c_RD, 32'd0); // LHU off2
        step(0, 1, 0, 0, 1, 5'd14, 2'b01, 3'd0, 32'h0000_1000, c_RD, 32'd0); // LW  off0
        step(0, 1, 0, 0, 1, 5'd15, 2'b01, 3'd7, 32'h0000_1000, c_RD, 32'd0); // reserved -> LW
        step(0, 1, 0, 0, 1, 5'd16, 2'b00, 3'd1, 32'h0000_1003, c_RD, 32'd0); // ALU ignores offset

        // Misaligned LW, then misaligned LH held by a stall
        step(0, 1, 0, 0, 1, 5'd7, 2'b01, 3'd0, 32'h0000_2002, c_RD, 32'd0);
        idle();
        step(0, 1, 0, 0, 1, 5'd8, 2'b01, 3'd1, 32'h0000_2001, c_RD, 32'd0);
        step(0, 0, 1, 0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0);
        idle();
        idle();

        // JAL held for 3 stall cycles, then a single write to r31
        step(0, 1, 0, 0, 1, 5'd31, 2'b10, 3'd0, 32'h0000_0044, 32'd0, 32'h0040_0008);
        repeat (3) step(0, 1, 1, 0, 1, 5'd3, 2'b00, 3'd0, 32'h5555_5555, 32'd0, 32'd0);
        idle();
        // Stall and flush together: flush wins, no write, no retire
        step(0, 1, 0, 0, 1, 5'd3, 2'b00, 3'd0, 32'h0000_0333, 32'd0, 32'd0);
        step(0, 1, 1, 1, 1, 5'd4, 2'b00, 3'd0, 32'h0000_0444, 32'd0, 32'd0);
        idle();
        // Plain flush of a valid instruction
        step(0, 1, 0, 0, 1, 5'd6, 2'b00, 3'd0, 32'h0000_0666, 32'd0, 32'd0);
        step(0, 0, 0, 1, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0);
        idle();

        // Counter wrap: reset, then retire 17 instructions
        step(1, 0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 17; i++)
            step(0, 1, 0, 0, 1, 5'(i + 1), 2'b00, 3'd0, 32'(i * 3), 32'd0, 32'd0);
        idle();
        idle();
        // Reset in mid-stream
        step(0, 1, 0, 0, 1, 5'd2, 2'b00, 3'd0, 32'h0000_0222, 32'd0, 32'd0);
        step(1, 1, 0, 0, 1, 5'd3, 2'b00, 3'd0, 32'h0000_0333, 32'd0, 32'd0);
        idle();

        // Mixed random traffic
        for (int i = 0; i < 60; i++)
            step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 1'($urandom), 5'($urandom),
                 2'($urandom), 3'($urandom_range(0, 5)), $urandom, $urandom, $urandom);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
